aes_round_controller: RTL and testbench
=======================================

Name: aes_round_controller

Overview:
- Sequences one AES-128 encryption across the shared key-expansion unit and the shared round datapath.
- Latches key and plaintext on a load handshake. Steps the round index 1..11 and holds the previous-round key and the running cipher state. Captures each unit's output once its registered S-box latency has elapsed.
- Sits between the SPI/load front end and the two datapath blocks. Owns all round sequencing, so neither datapath block keeps any round state.

Parameters:
- SUB_LAT, 1, cycles from stable inputs to valid output on both the key-expansion and round datapath units (registered sub_bytes); legal range 1..3.
- NUM_ROUNDS, 11, number of round indices driven (1 = initial AddRoundKey, 11 = final round).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  start request; sampled only in IDLE or DONE.
- key  in  128  cipher key; captured on accepted load.
- plaintext  in  128  input block; captured on accepted load.
- ready  out  1  high in IDLE and DONE (load will be accepted).
- done  out  1  high in DONE only.
- cyphertext  out  128  final state; valid while done=1.
- ke_round  out  4  round index to key-expansion unit.
- ke_key  out  128  latched cipher key to key-expansion unit.
- ke_prev_key  out  128  previous round key register.
- ke_round_key  in  128  round key from key-expansion unit.
- rd_state  out  128  current state register to round datapath.
- rd_round_key  out  128  captured round key register.
- rd_first  out  1  high when ke_round=1 (AddRoundKey only).
- rd_last  out  1  high when ke_round=NUM_ROUNDS (skip MixColumns).
- rd_result  in  128  round datapath output.

Behaviour:
- Reset (async, reset_n=0) forces FSM to IDLE, phase counter to 0, and round register to 1.
  - Clears all 128-bit registers (key, prev_key, rk, state) to 0.
  - Outputs during reset: ready=1, done=0, cyphertext=0.
  - Reset mid-operation abandons the block with no partial output.
- FSM states: IDLE, KEY, DATA, DONE.
- IDLE/DONE with load=1 performs the following on that edge:
  - key_reg<=key; state_reg<=plaintext; prev_key<=key; round<=1; cnt<=0.
  - Next state is KEY, and ready/done drop on the following cycle.
- load while in KEY or DATA is ignored (no restart, no error).
- KEY phase:
  - Drives ke_round=round, ke_key=key_reg, ke_prev_key=prev_key.
  - cnt counts 0..SUB_LAT, and inputs are held constant throughout.
  - At cnt==SUB_LAT: rk_reg<=ke_round_key; prev_key<=ke_round_key; cnt<=0; next state DATA.
- DATA phase:
  - Drives rd_state=state_reg, rd_round_key=rk_reg, rd_first, rd_last.
  - cnt counts 0..SUB_LAT.
  - At cnt==SUB_LAT, state_reg<=rd_result.
  - If round==NUM_ROUNDS, next state is DONE; otherwise round<=round+1, cnt<=0, next state KEY.
- Round 1: the key-expansion unit returns the key itself, and the round datapath with rd_first=1 returns plaintext^key. The controller still spends the full KEY+DATA time for uniform timing.
- Latency:
  - Each round takes 2*(SUB_LAT+1) cycles.
  - From the load-accept edge to done=1 takes NUM_ROUNDS*2*(SUB_LAT+1) cycles (44 at defaults).
- DONE state:
  - cyphertext=state_reg, done=1, ready=1; all held until a new load is accepted.
  - A new load in DONE restarts directly; there is no IDLE bubble.
- Output rules:
  - ke_round holds its value through both phases of a round and never leaves 1..NUM_ROUNDS.
  - ke_round=round is also held in IDLE and DONE.
  - rd_first and rd_last are decoded from the round register, not registered separately.
  - The round counter never wraps: the increment is suppressed at NUM_ROUNDS.

Decomposition:
- Package aes_pkg holds:
  - the ctrl_state_t enum {IDLE, KEY, DATA, DONE};
  - constants ROUND_W=4, FIRST_ROUND=4'd1, NUM_ROUNDS=4'd11;
  - the typedef block_t = logic [127:0].
- One sub-module, aes_phase_timer, contains the cnt register and compare. It takes clk, reset_n, clear and en, and outputs expire (cnt==SUB_LAT).

Test Plan:
- Reset check: assert reset_n=0 mid-DATA of round 5. Require immediate ready=1, done=0, cyphertext=0, ke_round=1. Deassert, load again, and require a full 44-cycle run.
- FIPS-197 C.1 end-to-end with the real key_expansion and round datapath: key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff. Require cyphertext=69c4e0d86a7b0430d8cdb78070b4c55a with done=1 exactly 44 cycles after load accept.
- Round sequencing with stub units (latency SUB_LAT): record ke_round per cycle. Require each value 1..11 to be held for 4 consecutive cycles, rd_first=1 only in round 1, and rd_last=1 only in round 11.
- Capture timing with stubs returning a cycle-stamped value: require rk_reg and state_reg to take the value present at cnt==SUB_LAT, never earlier. Repeat with SUB_LAT=2 and require an 66-cycle total.
- Load while busy: pulse load with a different key at rounds 3 and 7. Require no restart and the same C.1 cyphertext.
- Back-to-back: hold load=1 in DONE with a new plaintext. Require done to drop the next cycle, ke_round=1, and a second result 44 cycles later.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencing slice.
// Imported by the controller and its phase timer.
package aes_pkg;

  localparam int ROUND_W = 4;
  localparam logic [ROUND_W-1:0] FIRST_ROUND = 4'd1;
  localparam logic [ROUND_W-1:0] NUM_ROUNDS = 4'd11;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    KEY,
    DATA,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/aes_phase_timer.sv
// Phase counter: counts 0..SUB_LAT while enabled, wraps on expire.
// expire marks the cycle a shared unit's registered output is valid.
module aes_phase_timer #(
  parameter int unsigned SUB_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(SUB_LAT + 1);

  logic [CW-1:0] cnt;

  assign expire = (cnt == CW'(SUB_LAT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= expire ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/aes_round_controller.sv
// Sequences one AES-128 block through shared key-expansion and round units.
// Holds round index, previous round key and running state between phases.
module aes_round_controller
  import aes_pkg::*;
#(
  parameter int unsigned SUB_LAT = 1,
  parameter logic [ROUND_W-1:0] NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         ready,
  output logic         done,
  output logic [127:0] cyphertext,
  output logic [3:0]   ke_round,
  output logic [127:0] ke_key,
  output logic [127:0] ke_prev_key,
  input  logic [127:0] ke_round_key,
  output logic [127:0] rd_state,
  output logic [127:0] rd_round_key,
  output logic         rd_first,
  output logic         rd_last,
  input  logic [127:0] rd_result
);

  ctrl_state_t state_q;
  ctrl_state_t state_d;

  logic [ROUND_W-1:0] round_q;
  block_t key_q;
  block_t prev_key_q;
  block_t rk_q;
  block_t data_q;

  logic expire;
  logic busy;
  logic accept;
  logic key_cap;
  logic data_cap;
  logic last;

  assign busy     = (state_q == KEY) || (state_q == DATA);
  assign ready    = (state_q == IDLE) || (state_q == DONE);
  assign accept   = load && ready;
  assign key_cap  = (state_q == KEY) && expire;
  assign data_cap = (state_q == DATA) && expire;
  assign last     = (round_q == NUM_ROUNDS);

  aes_phase_timer #(
    .SUB_LAT(SUB_LAT)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .en     (busy),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (accept) state_d = KEY;
      KEY:        if (expire) state_d = DATA;
      DATA:       if (expire) state_d = last ? DONE : KEY;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      round_q    <= FIRST_ROUND;
      key_q      <= '0;
      prev_key_q <= '0;
      rk_q       <= '0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (1'b1)
        accept: begin
          key_q      <= key;
          prev_key_q <= key;
          data_q     <= plaintext;
          round_q    <= FIRST_ROUND;
        end
        key_cap: begin
          rk_q       <= ke_round_key;
          prev_key_q <= ke_round_key;
        end
        data_cap: begin
          data_q <= rd_result;
          // Saturate at the final round so the index never wraps.
          if (!last) round_q <= round_q + ROUND_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign done         = (state_q == DONE);
  assign cyphertext   = done ? data_q : '0;
  assign ke_round     = round_q;
  assign ke_key       = key_q;
  assign ke_prev_key  = prev_key_q;
  assign rd_state     = data_q;
  assign rd_round_key = rk_q;
  assign rd_first     = (round_q == FIRST_ROUND);
  assign rd_last      = last;

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller with behavioural key-expansion and
// round units, plus a SUB_LAT=2 instance for latency scaling.
module tb_aes_round_controller;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [95:0]  KE_TAG = 96'hC0FFEE00_11111111_22222222;
  localparam logic [95:0]  RD_TAG = 96'hDA7A0000_33333333_44444444;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic load_a = 1'b0;
  logic load_b = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] pt = '0;
  logic stamp = 1'b0;
  logic [31:0] cyc = '0;
  int tests = 0;
  int fails = 0;
  logic [7:0] sb [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  logic ready_a, done_a, rd_first_a, rd_last_a;
  logic [3:0] ke_round_a;
  logic [127:0] ct_a, ke_key_a, ke_prev_a, ke_rk_a;
  logic [127:0] rd_state_a, rd_rk_a, rd_res_a;
  logic ready_b, done_b, rd_first_b, rd_last_b;
  logic [3:0] ke_round_b;
  logic [127:0] ct_b, ke_key_b, ke_prev_b, ke_rk_b;
  logic [127:0] rd_state_b, rd_rk_b, rd_res_b;

  aes_round_controller u_dut_a (
    .clk(clk), .reset_n(reset_n), .load(load_a),
    .key(key), .plaintext(pt),
    .ready(ready_a), .done(done_a), .cyphertext(ct_a),
    .ke_round(ke_round_a), .ke_key(ke_key_a),
    .ke_prev_key(ke_prev_a), .ke_round_key(ke_rk_a),
    .rd_state(rd_state_a), .rd_round_key(rd_rk_a),
    .rd_first(rd_first_a), .rd_last(rd_last_a),
    .rd_result(rd_res_a)
  );

  aes_round_controller #(.SUB_LAT(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .load(load_b),
    .key(key), .plaintext(pt),
    .ready(ready_b), .done(done_b), .cyphertext(ct_b),
    .ke_round(ke_round_b), .ke_key(ke_key_b),
    .ke_prev_key(ke_prev_b), .ke_round_key(ke_rk_b),
    .rd_state(rd_state_b), .rd_round_key(rd_rk_b),
    .rd_first(rd_first_b), .rd_last(rd_last_b),
    .rd_result(rd_res_b)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ke_model(input logic [127:0] k,
                                            input logic [127:0] prev,
                                            input logic [3:0] rnd);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0] rc;
    if (rnd == 4'd1) return k;
    rc = 8'h01;
    for (int i = 2; i < int'(rnd); i++) rc = xt(rc);
    {w0, w1, w2, w3} = prev;
    t = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]};
    t = t ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] rd_model(input logic [127:0] s,
                                            input logic [127:0] rk,
                                            input logic first,
                                            input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] x0, x1, x2, x3;
    logic [127:0] o;
    if (first) return s ^ rk;
    for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
        b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
        b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
        b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ rk;
  endfunction

  // Registered unit models: SUB_LAT pipeline stages behind the inputs.
  logic [127:0] ke_pa, rd_pa, ke_pb1, ke_pb2, rd_pb1, rd_pb2;
  always @(posedge clk) begin
    ke_pa  <= ke_model(ke_key_a, ke_prev_a, ke_round_a);
    rd_pa  <= rd_model(rd_state_a, rd_rk_a, rd_first_a, rd_last_a);
    ke_pb1 <= ke_model(ke_key_b, ke_prev_b, ke_round_b);
    rd_pb1 <= rd_model(rd_state_b, rd_rk_b, rd_first_b, rd_last_b);
    ke_pb2 <= ke_pb1;
    rd_pb2 <= rd_pb1;
  end

  assign ke_rk_a  = stamp ? {KE_TAG, cyc} : ke_pa;
  assign rd_res_a = stamp ? {RD_TAG, cyc} : rd_pa;
  assign ke_rk_b  = stamp ? {KE_TAG, cyc} : ke_pb2;
  assign rd_res_b = stamp ? {RD_TAG, cyc} : rd_pb2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [127:0] k, input logic [127:0] p);
    key = k; pt = p; load_a = 1'b1;
    tick();
    load_a = 1'b0;
  endtask

  task automatic start_b(input logic [127:0] k, input logic [127:0] p);
    key = k; pt = p; load_b = 1'b1;
    tick();
    load_b = 1'b0;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    while (!done_a && n < 200) begin tick(); n++; end
  endtask

  task automatic wait_b(output int n);
    n = 0;
    while (!done_b && n < 200) begin tick(); n++; end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    tick(); tick();
    tests++;
    if (ready_a !== 1'b1 || done_a !== 1'b0 || ct_a !== '0 || ke_round_a !== 4'd1) begin
      fails++;
      $display("FAIL reset_state: ready=%b done=%b ct=%h round=%0d expected 1 0 0 1",
               ready_a, done_a, ct_a, ke_round_a);
    end
    reset_n = 1'b1;
    tick();
    start_a(C1_KEY, C1_PT);
    repeat (19) tick();
    tests++;
    if (ke_round_a !== 4'd5 || ready_a !== 1'b0) begin
      fails++;
      $display("FAIL mid_round5: round=%0d ready=%b expected 5 0", ke_round_a, ready_a);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (ready_a !== 1'b1 || done_a !== 1'b0 || ct_a !== '0 || ke_round_a !== 4'd1) begin
      fails++;
      $display("FAIL reset_async: ready=%b done=%b ct=%h round=%0d expected 1 0 0 1",
               ready_a, done_a, ct_a, ke_round_a);
    end
    tick();
    reset_n = 1'b1;
    tick();
    start_a(C1_KEY, C1_PT);
    wait_a(n);
    tests++;
    if (n !== 44 || ct_a !== C1_CT) begin
      fails++;
      $display("FAIL reset_rerun: cycles=%0d ct=%h expected 44 %h", n, ct_a, C1_CT);
    end
  endtask

  task automatic test_fips();
    int n;
    start_a(C1_KEY, C1_PT);
    tests++;
    if (ready_a !== 1'b0 || done_a !== 1'b0) begin
      fails++;
      $display("FAIL fips_busy: ready=%b done=%b expected 0 0", ready_a, done_a);
    end
    wait_a(n);
    tests++;
    if (n !== 44) begin
      fails++;
      $display("FAIL fips_latency: got %0d expected 44", n);
    end
    tests++;
    if (ct_a !== C1_CT || ready_a !== 1'b1) begin
      fails++;
      $display("FAIL fips_ct: got %h ready=%b expected %h 1", ct_a, ready_a, C1_CT);
    end
    tick(); tick();
    tests++;
    if (done_a !== 1'b1 || ct_a !== C1_CT || ke_round_a !== 4'd11) begin
      fails++;
      $display("FAIL done_hold: done=%b ct=%h round=%0d expected 1 %h 11",
               done_a, ct_a, ke_round_a, C1_CT);
    end
  endtask

  task automatic test_sequencing();
    start_a(B_KEY, B_PT);
    for (int k = 0; k < 44; k++) begin
      tests++;
      if (ke_round_a !== 4'(k / 4 + 1) || rd_first_a !== (k < 4) || rd_last_a !== (k >= 40)) begin
        fails++;
        $display("FAIL seq_c%0d: round=%0d first=%b last=%b expected %0d %b %b",
                 k, ke_round_a, rd_first_a, rd_last_a, k / 4 + 1, k < 4, k >= 40);
      end
      tick();
    end
    tests++;
    if (done_a !== 1'b1 || ct_a !== B_CT || ke_round_a !== 4'd11) begin
      fails++;
      $display("FAIL seq_end: done=%b ct=%h round=%0d expected 1 %h 11",
               done_a, ct_a, ke_round_a, B_CT);
    end
  endtask

  task automatic test_capture();
    int n;
    logic [31:0] c;
    stamp = 1'b1;
    start_a(C1_KEY, C1_PT);
    c = cyc;
    tick(); tick();
    tests++;
    if (rd_rk_a !== {KE_TAG, c + 32'd1} || ke_prev_a !== {KE_TAG, c + 32'd1}) begin
      fails++;
      $display("FAIL cap_key_l1: rk=%h prev=%h expected %h",
               rd_rk_a, ke_prev_a, {KE_TAG, c + 32'd1});
    end
    tick(); tick();
    tests++;
    if (rd_state_a !== {RD_TAG, c + 32'd3}) begin
      fails++;
      $display("FAIL cap_data_l1: got %h expected %h", rd_state_a, {RD_TAG, c + 32'd3});
    end
    wait_a(n);
    start_b(C1_KEY, C1_PT);
    c = cyc;
    repeat (3) tick();
    tests++;
    if (rd_rk_b !== {KE_TAG, c + 32'd2}) begin
      fails++;
      $display("FAIL cap_key_l2: got %h expected %h", rd_rk_b, {KE_TAG, c + 32'd2});
    end
    repeat (3) tick();
    tests++;
    if (rd_state_b !== {RD_TAG, c + 32'd5}) begin
      fails++;
      $display("FAIL cap_data_l2: got %h expected %h", rd_state_b, {RD_TAG, c + 32'd5});
    end
    wait_b(n);
    stamp = 1'b0;
    tick();
  endtask

  task automatic test_sublat2();
    int n;
    start_b(C1_KEY, C1_PT);
    wait_b(n);
    tests++;
    if (n !== 66 || ct_b !== C1_CT) begin
      fails++;
      $display("FAIL sublat2: cycles=%0d ct=%h expected 66 %h", n, ct_b, C1_CT);
    end
  endtask

  task automatic test_load_busy();
    int n;
    start_a(C1_KEY, C1_PT);
    n = 0;
    while (!done_a && n < 200) begin
      if (n == 9 || n == 25) begin
        key = B_KEY; pt = B_PT; load_a = 1'b1;
      end else begin
        load_a = 1'b0;
      end
      tick();
      n++;
    end
    load_a = 1'b0;
    tests++;
    if (n !== 44 || ct_a !== C1_CT) begin
      fails++;
      $display("FAIL load_busy: cycles=%0d ct=%h expected 44 %h", n, ct_a, C1_CT);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    key = B_KEY; pt = B_PT; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    tests++;
    if (done_a !== 1'b0 || ready_a !== 1'b0 || ke_round_a !== 4'd1) begin
      fails++;
      $display("FAIL b2b_restart: done=%b ready=%b round=%0d expected 0 0 1",
               done_a, ready_a, ke_round_a);
    end
    wait_a(n);
    tests++;
    if (n !== 44 || ct_a !== B_CT) begin
      fails++;
      $display("FAIL b2b_result: cycles=%0d ct=%h expected 44 %h", n, ct_a, B_CT);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    test_reset();
    test_fips();
    test_sequencing();
    test_capture();
    test_sublat2();
    test_load_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
